// File: rtl/mcpu_io_pkg.sv
// Shared definitions for the MCPU I/O hub: register window offsets,
// STATUS bit positions and the STATUS word packing helper.
package mcpu_io_pkg;

    // Word offsets inside the I/O register window
    localparam logic [3:0] IO_STATUS = 4'd0;
    localparam logic [3:0] IO_KBD    = 4'd1;
    localparam logic [3:0] IO_FRAME  = 4'd2;
    localparam logic [3:0] IO_KLEVEL = 4'd3;
    localparam logic [3:0] IO_CHAN0  = 4'd4;
    localparam logic [3:0] IO_TIMER  = 4'd14;

    // STATUS register bit positions
    localparam int STATUS_W     = 4;
    localparam int ST_VSYNC     = 0;
    localparam int ST_KBD_NE    = 1;
    localparam int ST_KBD_OVF   = 2;
    localparam int ST_TIMER_EXP = 3;

    // Assemble the STATUS word from its individual flags
    function automatic logic [STATUS_W-1:0] pack_status(
        input logic vsync_flag,
        input logic kbd_nonempty,
        input logic kbd_overflow,
        input logic timer_expired
    );
        logic [STATUS_W-1:0] s;
        s               = 4'b0000;
        s[ST_VSYNC]     = vsync_flag;
        s[ST_KBD_NE]    = kbd_nonempty;
        s[ST_KBD_OVF]   = kbd_overflow;
        s[ST_TIMER_EXP] = timer_expired;
        return s;
    endfunction

endpackage

// File: rtl/mcpu_io_hub_if.sv
// CPU-side register window bus of the MCPU I/O hub.
// master = CPU / address decoder side, slave = the hub.
interface mcpu_io_hub_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  io_sel;
    logic [3:0]            io_addr;
    logic                  io_re;
    logic                  io_we;
    logic [DATA_WIDTH-1:0] io_wdata;
    logic [DATA_WIDTH-1:0] io_rdata;
    logic                  io_rvalid;

    modport master (
        output io_sel, io_addr, io_re, io_we, io_wdata,
        input  io_rdata, io_rvalid
    );

    modport slave (
        input  io_sel, io_addr, io_re, io_we, io_wdata,
        output io_rdata, io_rvalid
    );
endinterface

// File: rtl/mcpu_io_fifo.sv
// Synchronous FIFO used for keyboard codes. DEPTH must be a power of two.
// A push while full is dropped and flagged on 'overflow' for that cycle,
// unless a pop happens in the same cycle, in which case both proceed.
// A pop while empty is ignored.
module mcpu_io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);
    localparam logic [LW-1:0] CNT_ONE    = LW'(1'b1);
    localparam logic [LW-1:0] CNT_FULL   = LW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {LW{1'b0}});
    assign level     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign overflow  = push & ~do_push_s;

    // Storage, pointers and occupancy; reset discards all contents
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/mcpu_io_hub.sv
// Memory-mapped I/O hub for the MCPU: synchronised input channels,
// keyboard code FIFO, vsync frame counter and sticky vsync flag behind
// one register window. Optional countdown timer enabled by defining
// MCPU_IO_TIMER_EN; without it TIMER reads 0 and STATUS[3] is tied 0.
module mcpu_io_hub
    import mcpu_io_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N_CHAN     = 4,
    parameter int CHAN_WIDTH = 8,
    parameter int KBD_DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    mcpu_io_hub_if.slave                 bus,
    input  logic                         vsync,
    input  logic [7:0]                   keycode,
    input  logic [N_CHAN*CHAN_WIDTH-1:0] chan_in,
    output logic                         vsync_flag
);
    localparam int LVL_W = $clog2(KBD_DEPTH) + 1;
    localparam logic [DATA_WIDTH-1:0] DW_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DW_ONE  = DATA_WIDTH'(1'b1);

    // Synchroniser stages plus one history stage for edge/change detection
    logic                         vsync_meta_r, vsync_sync_r, vsync_prev_r;
    logic [7:0]                   key_meta_r, key_sync_r, key_prev_r;
    logic [N_CHAN*CHAN_WIDTH-1:0] chan_meta_r, chan_sync_r;

    logic                  vsync_flag_r;
    logic                  kbd_ovf_r;
    logic [DATA_WIDTH-1:0] frame_cnt_r;
    logic [DATA_WIDTH-1:0] io_rdata_r;
    logic                  io_rvalid_r;

    logic                  vsync_rise_s;
    logic                  key_push_s;
    logic                  rd_en_s, wr_en_s;
    logic                  status_rd_s, kbd_rd_s, frame_wr_s;
    logic [7:0]            fifo_head_s;
    logic                  fifo_empty_s;
    logic                  kbd_full_unused_s;
    logic [LVL_W-1:0]      fifo_level_s;
    logic                  fifo_ovf_s;
    logic [STATUS_W-1:0]   status_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic [DATA_WIDTH-1:0] timer_cnt_s;
    logic                  timer_exp_s;

    // Two-flop synchronisers for every asynchronous input, plus history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_meta_r <= 1'b0;
            vsync_sync_r <= 1'b0;
            vsync_prev_r <= 1'b0;
            key_meta_r   <= 8'h00;
            key_sync_r   <= 8'h00;
            key_prev_r   <= 8'h00;
            chan_meta_r  <= {(N_CHAN*CHAN_WIDTH){1'b0}};
            chan_sync_r  <= {(N_CHAN*CHAN_WIDTH){1'b0}};
        end else begin
            vsync_meta_r <= vsync;
            vsync_sync_r <= vsync_meta_r;
            vsync_prev_r <= vsync_sync_r;
            key_meta_r   <= keycode;
            key_sync_r   <= key_meta_r;
            key_prev_r   <= key_sync_r;
            chan_meta_r  <= chan_in;
            chan_sync_r  <= chan_meta_r;
        end
    end

    assign vsync_rise_s = vsync_sync_r & ~vsync_prev_r;
    // A key is captured once when it appears or changes to another nonzero code
    assign key_push_s   = (key_sync_r != 8'h00) && (key_sync_r != key_prev_r);
    assign rd_en_s      = bus.io_sel & bus.io_re;
    assign wr_en_s      = bus.io_sel & bus.io_we;
    assign status_rd_s  = rd_en_s && (bus.io_addr == IO_STATUS);
    assign kbd_rd_s     = rd_en_s && (bus.io_addr == IO_KBD);
    assign frame_wr_s   = wr_en_s && (bus.io_addr == IO_FRAME);

    mcpu_io_fifo #(
        .WIDTH (8),
        .DEPTH (KBD_DEPTH)
    ) u_kbd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (key_push_s),
        .push_data (key_sync_r),
        .pop       (kbd_rd_s),
        .head      (fifo_head_s),
        .full      (kbd_full_unused_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level_s),
        .overflow  (fifo_ovf_s)
    );

    // Sticky flags (set beats read-clear) and the frame counter (write beats count)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_flag_r <= 1'b0;
            kbd_ovf_r    <= 1'b0;
            frame_cnt_r  <= DW_ZERO;
        end else begin
            if (vsync_rise_s) begin
                vsync_flag_r <= 1'b1;
            end else if (status_rd_s) begin
                vsync_flag_r <= 1'b0;
            end else begin
                vsync_flag_r <= vsync_flag_r;
            end
            if (fifo_ovf_s) begin
                kbd_ovf_r <= 1'b1;
            end else if (status_rd_s) begin
                kbd_ovf_r <= 1'b0;
            end else begin
                kbd_ovf_r <= kbd_ovf_r;
            end
            if (frame_wr_s) begin
                frame_cnt_r <= bus.io_wdata;
            end else if (vsync_rise_s) begin
                frame_cnt_r <= frame_cnt_r + DW_ONE;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

`ifdef MCPU_IO_TIMER_EN
    logic                  timer_wr_s;
    logic [DATA_WIDTH-1:0] timer_cnt_r;
    logic                  timer_exp_r;

    assign timer_wr_s = wr_en_s && (bus.io_addr == IO_TIMER);

    // Load-or-count-down timer; the 1->0 step raises a sticky expiry flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_cnt_r <= DW_ZERO;
            timer_exp_r <= 1'b0;
        end else begin
            if (timer_wr_s) begin
                timer_cnt_r <= bus.io_wdata;
            end else if (timer_cnt_r != DW_ZERO) begin
                timer_cnt_r <= timer_cnt_r - DW_ONE;
            end else begin
                timer_cnt_r <= timer_cnt_r;
            end
            if (!timer_wr_s && (timer_cnt_r == DW_ONE)) begin
                timer_exp_r <= 1'b1;
            end else if (status_rd_s) begin
                timer_exp_r <= 1'b0;
            end else begin
                timer_exp_r <= timer_exp_r;
            end
        end
    end

    assign timer_cnt_s = timer_cnt_r;
    assign timer_exp_s = timer_exp_r;
`else
    assign timer_cnt_s = DW_ZERO;
    assign timer_exp_s = 1'b0;
`endif

    assign status_s = pack_status(vsync_flag_r, ~fifo_empty_s, kbd_ovf_r, timer_exp_s);

    // Read data selection from pre-edge state; unmapped offsets read 0
    always_comb begin
        rd_data_s = DW_ZERO;
        case (bus.io_addr)
            IO_STATUS: rd_data_s = DATA_WIDTH'(status_s);
            IO_KBD:    rd_data_s = fifo_empty_s ? DW_ZERO : DATA_WIDTH'(fifo_head_s);
            IO_FRAME:  rd_data_s = frame_cnt_r;
            IO_KLEVEL: rd_data_s = DATA_WIDTH'(fifo_level_s);
            IO_TIMER:  rd_data_s = timer_cnt_s;
            default: begin
                for (int i = 0; i < N_CHAN; i++) begin
                    if (bus.io_addr == 4'(IO_CHAN0 + i)) begin
                        rd_data_s = DATA_WIDTH'(chan_sync_r[i*CHAN_WIDTH +: CHAN_WIDTH]);
                    end else begin
                        rd_data_s = rd_data_s;
                    end
                end
            end
        endcase
    end

    // Registered read response, valid for exactly the cycle after the strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_rdata_r  <= DW_ZERO;
            io_rvalid_r <= 1'b0;
        end else begin
            io_rvalid_r <= rd_en_s;
            io_rdata_r  <= rd_en_s ? rd_data_s : DW_ZERO;
        end
    end

    assign bus.io_rdata  = io_rdata_r;
    assign bus.io_rvalid = io_rvalid_r;
    assign vsync_flag    = vsync_flag_r;
endmodule

// File: tb/tb_mcpu_io_hub.sv
// Self-checking bench for mcpu_io_hub: register reads are queued with
// their expected value and compared when the registered response appears.
module tb_mcpu_io_hub;
    import mcpu_io_pkg::*;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int CW = 8;
    localparam int KD = 8;

    logic             clk;
    logic             reset;
    logic             vsync;
    logic [7:0]       keycode;
    logic [NC*CW-1:0] chan_in;
    logic             vsync_flag;

    int n_cmp;
    int n_fail;

    logic [DW-1:0] exp_q [$];
    string         tag_q [$];
    logic [DW-1:0] obs_q [$];

    mcpu_io_hub_if #(.DATA_WIDTH(DW)) bus ();

    mcpu_io_hub #(
        .DATA_WIDTH (DW),
        .N_CHAN     (NC),
        .CHAN_WIDTH (CW),
        .KBD_DEPTH  (KD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .vsync      (vsync),
        .keycode    (keycode),
        .chan_in    (chan_in),
        .vsync_flag (vsync_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every read response on the falling edge
    always @(negedge clk) begin
        if (bus.io_rvalid === 1'b1) obs_q.push_back(bus.io_rdata);
    end

    task automatic issue_read(input logic [3:0] a, input logic [DW-1:0] e, input string tag);
        @(negedge clk);
        bus.io_sel = 1'b1; bus.io_re = 1'b1; bus.io_we = 1'b0; bus.io_addr = a;
        exp_q.push_back(e); tag_q.push_back(tag);
        @(posedge clk); #1;
        bus.io_sel = 1'b0; bus.io_re = 1'b0;
    endtask

    task automatic issue_write(input logic [3:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bus.io_sel = 1'b1; bus.io_we = 1'b1; bus.io_re = 1'b0; bus.io_addr = a; bus.io_wdata = d;
        @(posedge clk); #1;
        bus.io_sel = 1'b0; bus.io_we = 1'b0;
    endtask

    task automatic issue_rw(input logic [3:0] a, input logic [DW-1:0] d, input logic [DW-1:0] e, input string tag);
        @(negedge clk);
        bus.io_sel = 1'b1; bus.io_we = 1'b1; bus.io_re = 1'b1; bus.io_addr = a; bus.io_wdata = d;
        exp_q.push_back(e); tag_q.push_back(tag);
        @(posedge clk); #1;
        bus.io_sel = 1'b0; bus.io_we = 1'b0; bus.io_re = 1'b0;
    endtask

    task automatic hold_key(input logic [7:0] code, input int n);
        @(negedge clk);
        keycode = code;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic pulse_vsync();
        @(negedge clk); vsync = 1'b1;
        repeat (4) @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.io_sel = 1'b0; bus.io_re = 1'b0; bus.io_we = 1'b0;
        bus.io_addr = 4'h0; bus.io_wdata = 16'h0000;
        keycode = 8'h00; vsync = 1'b0; chan_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    // Wait (bounded) until every queued read has produced a response
    task automatic wait_drain();
        int t;
        t = 0;
        while (obs_q.size() < exp_q.size() && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [DW-1:0] e, o;
        string tg;
        apply_reset();
        n_cmp++;
        if (bus.io_rvalid !== 1'b0 || bus.io_rdata !== 16'h0000 || vsync_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rvalid=%b rdata=%h vflag=%b, required 0/0000/0",
                     bus.io_rvalid, bus.io_rdata, vsync_flag);
        end
        hold_key(8'h33, 4);
        hold_key(8'h00, 4);
        issue_write(IO_FRAME, 16'h1234);
        pulse_vsync();
        n_cmp++;
        if (vsync_flag !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_vflag: got %b required 1", vsync_flag);
        end
        @(negedge clk);
        bus.io_sel = 1'b1; bus.io_re = 1'b1; bus.io_addr = IO_FRAME;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.io_rvalid !== 1'b1 || bus.io_rdata !== 16'h1235) begin
            n_fail++; $display("FAIL pre_reset_read: rvalid=%b rdata=%h required 1/1235", bus.io_rvalid, bus.io_rdata);
        end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.io_rvalid !== 1'b0 || bus.io_rdata !== 16'h0000 || vsync_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: rvalid=%b rdata=%h vflag=%b, required 0/0000/0",
                     bus.io_rvalid, bus.io_rdata, vsync_flag);
        end
        bus.io_sel = 1'b0; bus.io_re = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        issue_read(IO_KLEVEL, 16'h0000, "reset_klevel");
        issue_read(IO_FRAME,  16'h0000, "reset_frame");
        issue_read(IO_STATUS, 16'h0000, "reset_status");
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tg = tag_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s: no response, required %h", tg, e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL %s: got %h required %h", tg, o, e); end end
        end
        n_cmp++;
        if (bus.io_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL idle_rvalid: got %b required 0", bus.io_rvalid);
        end
    endtask

    task automatic test_kbd_sequence();
        logic [DW-1:0] e, o;
        string tg;
        apply_reset();
        hold_key(8'h41, 4);
        hold_key(8'h00, 4);
        hold_key(8'h41, 4);
        hold_key(8'h42, 4);
        hold_key(8'h00, 4);
        issue_read(IO_KLEVEL, 16'h0003, "kbd_level3");
        issue_read(IO_KBD,    16'h0041, "kbd_pop1");
        issue_read(IO_KBD,    16'h0041, "kbd_pop2");
        issue_read(IO_KBD,    16'h0042, "kbd_pop3");
        issue_read(IO_KBD,    16'h0000, "kbd_pop_empty");
        issue_read(IO_KLEVEL, 16'h0000, "kbd_level0");
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tg = tag_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s: no response, required %h", tg, e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL %s: got %h required %h", tg, o, e); end end
        end
    endtask

    task automatic test_kbd_overflow();
        logic [DW-1:0] e, o;
        string tg;
        apply_reset();
        for (int i = 0; i < KD + 2; i++) hold_key(8'(8'h10 + i), 3);
        hold_key(8'h00, 4);
        issue_read(IO_KLEVEL, 16'(KD), "ovf_level_full");
        issue_read(IO_STATUS, 16'h0006, "ovf_status1");
        issue_read(IO_STATUS, 16'h0002, "ovf_status2");
        for (int i = 0; i < KD; i++) issue_read(IO_KBD, 16'(16'h0010 + i), "ovf_pop");
        issue_read(IO_KLEVEL, 16'h0000, "ovf_level_empty");
        issue_read(IO_STATUS, 16'h0000, "ovf_status3");
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tg = tag_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s: no response, required %h", tg, e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL %s: got %h required %h", tg, o, e); end end
        end
    endtask

    task automatic test_frame();
        logic [DW-1:0] e, o;
        string tg;
        apply_reset();
        issue_write(IO_FRAME, 16'hFFFF);
        issue_read(IO_FRAME, 16'hFFFF, "frame_written");
        pulse_vsync();
        issue_read(IO_FRAME,  16'h0000, "frame_wrap");
        issue_read(IO_STATUS, 16'h0001, "frame_vflag_set");
        issue_read(IO_STATUS, 16'h0000, "frame_vflag_clr");
        issue_rw(IO_FRAME, 16'h00AB, 16'h0000, "frame_rw_old");
        issue_read(IO_FRAME, 16'h00AB, "frame_rw_new");
        pulse_vsync();
        issue_read(IO_FRAME, 16'h00AC, "frame_incr");
        issue_write(IO_KLEVEL, 16'h0005);
        issue_read(IO_KLEVEL, 16'h0000, "ro_write_ignored");
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tg = tag_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s: no response, required %h", tg, e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL %s: got %h required %h", tg, o, e); end end
        end
    endtask

    task automatic test_back_to_back_chan();
        logic [DW-1:0] e, o;
        string tg;
        apply_reset();
        @(posedge clk); #1;
        chan_in = {8'h3C, 8'hA5, 8'h22, 8'h11};
        issue_read(4'(IO_CHAN0 + 2), 16'h0000, "chan2_edge1");
        issue_read(4'(IO_CHAN0 + 2), 16'h0000, "chan2_edge2");
        issue_read(4'(IO_CHAN0 + 2), 16'h00A5, "chan2_edge3");
        issue_read(4'(IO_CHAN0 + 0), 16'h0011, "chan0");
        issue_read(4'(IO_CHAN0 + 1), 16'h0022, "chan1");
        issue_read(4'(IO_CHAN0 + 3), 16'h003C, "chan3");
        issue_read(4'hF, 16'h0000, "unmapped_f");
        issue_read(4'hC, 16'h0000, "unmapped_c");
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tg = tag_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s: no response, required %h", tg, e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL %s: got %h required %h", tg, o, e); end end
        end
    endtask

    task automatic test_timer();
        logic [DW-1:0] e, o;
        string tg;
        apply_reset();
        issue_write(IO_TIMER, 16'h0005);
`ifdef MCPU_IO_TIMER_EN
        for (int i = 5; i >= 0; i--) issue_read(IO_TIMER, 16'(i), "timer_count");
        issue_read(IO_STATUS, 16'h0008, "timer_expired");
        issue_read(IO_STATUS, 16'h0000, "timer_exp_clr");
        issue_read(IO_TIMER,  16'h0000, "timer_stopped");
`else
        for (int i = 5; i >= 0; i--) issue_read(IO_TIMER, 16'h0000, "timer_absent");
        issue_read(IO_STATUS, 16'h0000, "timer_status_tied");
`endif
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); tg = tag_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s: no response, required %h", tg, e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL %s: got %h required %h", tg, o, e); end end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b0; vsync = 1'b0; keycode = 8'h00; chan_in = '0;
        bus.io_sel = 1'b0; bus.io_re = 1'b0; bus.io_we = 1'b0;
        bus.io_addr = 4'h0; bus.io_wdata = 16'h0000;
        test_reset();
        test_kbd_sequence();
        test_kbd_overflow();
        test_frame();
        test_back_to_back_chan();
        test_timer();
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL stray_responses: got %0d extra, required 0", obs_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
